// File: rtl/multi_button_vote_ctrl_if.sv
// Panel-side bundle for the vote qualifier: raw button levels and enable in,
// qualified vote pulse, conflict flag, busy and running total out.
interface multi_button_vote_ctrl_if #(
  parameter int NUM_BUTTONS = 4,
  parameter int IDX_W       = 2,
  parameter int TOTAL_W     = 16
);
  logic                   enable;
  logic [NUM_BUTTONS-1:0] button;
  logic                   valid_vote;
  logic [NUM_BUTTONS-1:0] vote_onehot;
  logic [IDX_W-1:0]       vote_idx;
  logic                   conflict;
  logic                   busy;
  logic [TOTAL_W-1:0]     total_votes;

  modport master (
    output enable, button,
    input  valid_vote, vote_onehot, vote_idx, conflict, busy, total_votes
  );

  modport slave (
    input  enable, button,
    output valid_vote, vote_onehot, vote_idx, conflict, busy, total_votes
  );
endinterface

// File: rtl/multi_button_vote_ctrl.sv
// Long-press vote qualifier: one tagged pulse per valid single-button hold,
// ambiguous presses abort with a conflict pulse, full release re-arms.
module multi_button_vote_ctrl #(
  parameter int NUM_BUTTONS = 4,
  parameter int HOLD_CYCLES = 10,
  parameter int IDX_W       = 2,
  parameter int HOLD_W      = 8,
  parameter int TOTAL_W     = 16
) (
  input  logic                    clock_i,
  input  logic                    reset_i,
  multi_button_vote_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    HOLD         = 2'd1,
    WAIT_RELEASE = 2'd2
  } state_e;

  localparam logic [NUM_BUTTONS-1:0] ONE_B    = NUM_BUTTONS'(1);
  localparam logic [HOLD_W-1:0]      LAST_CNT = HOLD_W'(HOLD_CYCLES - 1);

  state_e                 state_q;
  logic [HOLD_W-1:0]      cnt_q;
  logic [IDX_W-1:0]       idx_q;
  logic                   armed_q;
  logic                   valid_q;
  logic [NUM_BUTTONS-1:0] onehot_q;
  logic [IDX_W-1:0]       vote_idx_q;
  logic                   conflict_q;
  logic                   busy_q;
  logic [TOTAL_W-1:0]     total_q;
  logic [TOTAL_W-1:0]     total_d;

  logic                   any_s;
  logic                   single_s;
  logic                   own_s;
  logic                   others_s;
  logic [IDX_W-1:0]       first_idx_s;
  logic [NUM_BUTTONS-1:0] idx_mask_s;

  // Decode the button vector relative to the captured index.
  always_comb begin
    any_s       = |bus.button;
    single_s    = any_s && ((bus.button & (bus.button - ONE_B)) == '0);
    first_idx_s = '0;
    for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
      first_idx_s = bus.button[i] ? IDX_W'(i) : first_idx_s;
    end
    idx_mask_s = ONE_B << idx_q;
    own_s      = |(bus.button & idx_mask_s);
    others_s   = |(bus.button & ~idx_mask_s);
    total_d    = (&total_q) ? total_q : total_q + TOTAL_W'(1);
  end

  // Qualification FSM with registered pulse, index, busy and total outputs.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      armed_q    <= 1'b1;
      valid_q    <= 1'b0;
      onehot_q   <= '0;
      vote_idx_q <= '0;
      conflict_q <= 1'b0;
      busy_q     <= 1'b0;
      total_q    <= '0;
    end else begin
      valid_q    <= 1'b0;
      onehot_q   <= '0;
      vote_idx_q <= '0;
      conflict_q <= 1'b0;
      // A press seen while the window is closed must be released before it counts.
      armed_q    <= !any_s ? 1'b1 : (bus.enable ? armed_q : 1'b0);
      case (state_q)
        IDLE: begin
          if (bus.enable && armed_q && single_s) begin
            idx_q   <= first_idx_s;
            cnt_q   <= HOLD_W'(1);
            state_q <= HOLD;
            busy_q  <= 1'b1;
          end else if (bus.enable && armed_q && any_s) begin
            conflict_q <= 1'b1;
            state_q    <= WAIT_RELEASE;
            busy_q     <= 1'b1;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        HOLD: begin
          if (!bus.enable) begin
            cnt_q   <= '0;
            state_q <= WAIT_RELEASE;
            busy_q  <= 1'b1;
          end else if (others_s) begin
            cnt_q      <= '0;
            conflict_q <= 1'b1;
            state_q    <= WAIT_RELEASE;
            busy_q     <= 1'b1;
          end else if (!own_s) begin
            cnt_q   <= '0;
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (cnt_q == LAST_CNT) begin
            cnt_q      <= '0;
            valid_q    <= 1'b1;
            onehot_q   <= idx_mask_s;
            vote_idx_q <= idx_q;
            total_q    <= total_d;
            state_q    <= WAIT_RELEASE;
            busy_q     <= 1'b1;
          end else begin
            cnt_q   <= cnt_q + HOLD_W'(1);
            state_q <= HOLD;
            busy_q  <= 1'b1;
          end
        end
        WAIT_RELEASE: begin
          if (!any_s) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= WAIT_RELEASE;
            busy_q  <= 1'b1;
          end
        end
        default: begin
          cnt_q   <= '0;
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.valid_vote  = valid_q;
  assign bus.vote_onehot = onehot_q;
  assign bus.vote_idx    = vote_idx_q;
  assign bus.conflict    = conflict_q;
  assign bus.busy        = busy_q;
  assign bus.total_votes = total_q;

endmodule

// File: tb/tb_multi_button_vote_ctrl.sv
// Randomised and directed bench for multi_button_vote_ctrl against a
// press-length reference model; a narrow-total copy exercises saturation.
module tb_multi_button_vote_ctrl;

  localparam int NB  = 4;
  localparam int HC  = 10;
  localparam int IW  = 2;
  localparam int HW  = 8;
  localparam int TW  = 16;
  localparam int TW2 = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  multi_button_vote_ctrl_if #(.NUM_BUTTONS(NB), .IDX_W(IW), .TOTAL_W(TW))  bus ();
  multi_button_vote_ctrl_if #(.NUM_BUTTONS(NB), .IDX_W(IW), .TOTAL_W(TW2)) bus2 ();

  multi_button_vote_ctrl #(
    .NUM_BUTTONS(NB), .HOLD_CYCLES(HC), .IDX_W(IW), .HOLD_W(HW), .TOTAL_W(TW)
  ) dut (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus.slave)
  );

  multi_button_vote_ctrl #(
    .NUM_BUTTONS(NB), .HOLD_CYCLES(HC), .IDX_W(IW), .HOLD_W(HW), .TOTAL_W(TW2)
  ) dut_sat (
    .clock_i (clk),
    .reset_i (rst),
    .bus     (bus2.slave)
  );

  int vec_cnt = 0;
  int err_cnt = 0;

  // Reference model: length of the current single-button run, whether a
  // full release is still owed, and whether a press is blocked by a closed window.
  int m_run     = 0;
  int m_idx     = 0;
  bit m_blocked = 1'b0;
  bit m_armed   = 1'b1;
  int e_valid, e_onehot, e_idx, e_conflict, e_busy;
  int e_total   = 0;
  int e_total2  = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_update(input logic r, input logic en, input logic [NB-1:0] btn);
    bit arm_next;
    e_valid    = 0;
    e_onehot   = 0;
    e_idx      = 0;
    e_conflict = 0;
    if (r) begin
      m_run     = 0;
      m_blocked = 1'b0;
      m_armed   = 1'b1;
      e_total   = 0;
      e_total2  = 0;
    end else begin
      arm_next = (btn == '0) ? 1'b1 : (en ? m_armed : 1'b0);
      if (m_blocked) begin
        if (btn == '0) m_blocked = 1'b0;
      end else if (m_run > 0) begin
        if (!en) begin
          m_blocked = 1'b1;
          m_run     = 0;
        end else if ((int'(btn) & ~(1 << m_idx)) != 0) begin
          e_conflict = 1;
          m_blocked  = 1'b1;
          m_run      = 0;
        end else if (btn == '0) begin
          m_run = 0;
        end else begin
          m_run++;
          if (m_run == HC) begin
            e_valid   = 1;
            e_onehot  = int'(btn);
            e_idx     = m_idx;
            e_total   = (e_total == (2 ** TW) - 1) ? e_total : e_total + 1;
            e_total2  = (e_total2 == (2 ** TW2) - 1) ? e_total2 : e_total2 + 1;
            m_blocked = 1'b1;
            m_run     = 0;
          end
        end
      end else if (en && m_armed && btn != '0) begin
        if ($countones(btn) == 1) begin
          m_run = 1;
          m_idx = $clog2(int'(btn));
        end else begin
          e_conflict = 1;
          m_blocked  = 1'b1;
        end
      end
      m_armed = arm_next;
    end
    e_busy = (m_blocked || m_run > 0) ? 1 : 0;
  endtask

  task automatic step(input logic r, input logic en, input logic [NB-1:0] b);
    rst         = r;
    bus.enable  = en;
    bus.button  = b;
    bus2.enable = en;
    bus2.button = b;
    @(posedge clk);
    model_update(r, en, b);
    #1;
    check_val("valid_vote",  32'(bus.valid_vote),   32'(e_valid));
    check_val("vote_onehot", 32'(bus.vote_onehot),  32'(e_onehot));
    check_val("vote_idx",    32'(bus.vote_idx),     32'(e_idx));
    check_val("conflict",    32'(bus.conflict),     32'(e_conflict));
    check_val("busy",        32'(bus.busy),         32'(e_busy));
    check_val("total_votes", 32'(bus.total_votes),  32'(e_total));
    check_val("total_sat",   32'(bus2.total_votes), 32'(e_total2));
  endtask

  task automatic hold(input logic en, input logic [NB-1:0] b, input int n);
    for (int k = 0; k < n; k++) step(1'b0, en, b);
  endtask

  initial begin
    logic [NB-1:0] pat;
    logic          en;
    int            len;
    int            kind;

    bus.enable  = 1'b0;
    bus.button  = '0;
    bus2.enable = 1'b0;
    bus2.button = '0;

    step(1'b1, 1'b0, 4'b0000);
    step(1'b1, 1'b1, 4'b0000);

    // Basic long press on button 2, then release.
    hold(1'b1, 4'b0100, 10);
    hold(1'b1, 4'b0100, 3);
    hold(1'b1, 4'b0000, 2);

    // Short press dropped, then a full press of button 0.
    hold(1'b1, 4'b0001, 9);
    hold(1'b1, 4'b0000, 2);
    hold(1'b1, 4'b0001, 10);
    hold(1'b1, 4'b0000, 2);

    // Simultaneous press, and a second button joining mid-hold.
    hold(1'b1, 4'b0011, 3);
    hold(1'b1, 4'b0000, 2);
    hold(1'b1, 4'b0010, 5);
    hold(1'b1, 4'b1010, 3);
    hold(1'b1, 4'b0010, 15);
    hold(1'b1, 4'b0000, 2);

    // Long hold gives one pulse; brief release then re-press gives another.
    hold(1'b1, 4'b1000, 50);
    hold(1'b1, 4'b0000, 1);
    hold(1'b1, 4'b1000, 10);
    hold(1'b1, 4'b0000, 2);

    // Enable drop mid-press, and a press already held when enable rises.
    hold(1'b1, 4'b0100, 5);
    hold(1'b0, 4'b0100, 2);
    hold(1'b1, 4'b0100, 12);
    hold(1'b1, 4'b0000, 1);
    hold(1'b1, 4'b0100, 10);
    hold(1'b1, 4'b0000, 2);
    hold(1'b0, 4'b0001, 3);
    hold(1'b1, 4'b0001, 14);
    hold(1'b1, 4'b0000, 2);

    // Reset during a hold, then enough votes to saturate the narrow total.
    hold(1'b1, 4'b0010, 6);
    step(1'b1, 1'b1, 4'b0010);
    hold(1'b1, 4'b0010, 10);
    hold(1'b1, 4'b0000, 1);
    for (int v = 0; v < 4; v++) begin
      hold(1'b1, 4'b0001 << (v % NB), 10);
      hold(1'b1, 4'b0000, 1);
    end

    // Random press segments.
    for (int s = 0; s < 400; s++) begin
      kind = $urandom_range(0, 9);
      if (kind < 6)       pat = 4'b0001 << $urandom_range(0, NB - 1);
      else if (kind < 8)  pat = NB'($urandom_range(1, (1 << NB) - 1));
      else                pat = '0;
      len = (kind < 6 && $urandom_range(0, 1) == 1) ? $urandom_range(HC - 1, HC + 2)
                                                    : $urandom_range(1, 14);
      en  = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 99) == 0) step(1'b1, en, pat);
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 19) == 0) en = ~en;
        step(1'b0, en, pat);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
